// File: rtl/dmux_1x2_sched.sv
// Streaming 1-to-2 demultiplexer scheduler: one-entry holding register per output, static or
// round-robin steering, per-output beat counters and a flush/drain FSM. Option macro: DMUX_BURST_EN.
module dmux_1x2_sched #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             sel,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             rr_ptr,
  output logic             flush_done,
  output logic [1:0]       dbg_state
);

  // Handshake: a beat moves on a port in every cycle where its valid and ready are both high;
  // outN_valid never depends on outN_ready, while in_ready may depend on the destination's ready.

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_flush_done;
  logic             r_out0_valid;
  logic             r_out1_valid;
  logic [WIDTH-1:0] r_out0_data;
  logic [WIDTH-1:0] r_out1_data;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             r_rr_ptr;

  logic w_dest;
  logic w_dest_free;
  logic w_accept;
  logic w_acc0;
  logic w_acc1;

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("BURST_LEN must be >= 1");
  end

  assign w_dest      = mode ? r_rr_ptr : sel;
  assign w_dest_free = w_dest ? (!r_out1_valid || out1_ready) : (!r_out0_valid || out0_ready);
  assign in_ready    = (r_state == ST_RUN) && w_dest_free;
  assign w_accept    = in_valid && in_ready;
  assign w_acc0      = w_accept && !w_dest;
  assign w_acc1      = w_accept && w_dest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out0_valid <= 1'b0;
      r_out0_data  <= '0;
      r_cnt0       <= '0;
    end else if (w_acc0) begin
      r_out0_valid <= 1'b1;
      r_out0_data  <= in_data;
      r_cnt0       <= r_cnt0 + CNT_W'(1);
    end else if (out0_ready) begin
      r_out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out1_valid <= 1'b0;
      r_out1_data  <= '0;
      r_cnt1       <= '0;
    end else if (w_acc1) begin
      r_out1_valid <= 1'b1;
      r_out1_data  <= in_data;
      r_cnt1       <= r_cnt1 + CNT_W'(1);
    end else if (out1_ready) begin
      r_out1_valid <= 1'b0;
    end
  end

`ifdef DMUX_BURST_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  logic [BW-1:0] r_burst_cnt;

  // The pointer advances only after BURST_LEN beats have gone to the current destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_cnt <= '0;
      r_rr_ptr    <= 1'b0;
    end else if (!mode) begin
      r_burst_cnt <= '0;
    end else if (w_accept) begin
      if (r_burst_cnt == BURST_LAST) begin
        r_burst_cnt <= '0;
        r_rr_ptr    <= ~r_rr_ptr;
      end else begin
        r_burst_cnt <= r_burst_cnt + BW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (mode && w_accept) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end
`endif

  // A beat accepted in the cycle flush is sampled still lands; FLUSH then only waits for both
  // holding registers to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (flush) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!r_out0_valid && !r_out1_valid) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= flush ? ST_FLUSH : ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign out0_valid = r_out0_valid;
  assign out0_data  = r_out0_data;
  assign out1_valid = r_out1_valid;
  assign out1_data  = r_out1_data;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;
  assign rr_ptr     = r_rr_ptr;
  assign flush_done = r_flush_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_dmux_1x2_sched.sv
// Bench for dmux_1x2_sched: cycle vector table plus hand sequences for flush, counter wrap and
// asynchronous reset; output data is checked through per-output expected queues.
module tb_dmux_1x2_sched;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

`ifdef DMUX_BURST_EN
  localparam int         BURST = 4;
  localparam logic [7:0] K0    = 8'd4;
  localparam logic [7:0] K1    = 8'd3;
  localparam logic       RR1   = 1'b1;
`else
  localparam int         BURST = 1;
  localparam logic [7:0] K0    = 8'd2;
  localparam logic [7:0] K1    = 8'd5;
  localparam logic       RR1   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             mode, sel, flush, in_valid, in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready, out1_valid, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             rr_ptr, flush_done;
  logic [1:0]       dbg_state;

  dmux_1x2_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1), .rr_ptr(rr_ptr), .flush_done(flush_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ctl = {mode, sel, flush, in_valid}; rdy = {out0_ready, out1_ready};
  // e_hs = {in_ready, out0_valid, out1_valid}; e_rf = {rr_ptr, flush_done}
  typedef struct {
    logic [3:0] ctl;
    logic [7:0] data;
    logic [1:0] rdy;
    logic [2:0] e_hs;
    logic [7:0] e_cnt0;
    logic [7:0] e_cnt1;
    logic [1:0] e_rf;
  } vec_t;

  vec_t             tbl[$];
  logic [WIDTH-1:0] exp0_q[$];
  logic [WIDTH-1:0] exp1_q[$];
  int               n_vec  = 0;
  int               n_miss = 0;
  logic             m_rr   = 1'b0;
  int               m_bcnt = 0;
  logic             ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [7:0] d, input logic [1:0] rdy);
    {mode, sel, flush, in_valid} = ctl;
    in_data = d;
    {out0_ready, out1_ready} = rdy;
  endtask

  // scoreboard: called mid-cycle, before the edge that completes the observed handshakes
  task automatic sb_sample();
    logic       d;
    logic [7:0] e;
    if (out0_valid && out0_ready) begin
      if (exp0_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL out0 unexpected beat: got %0h, expected none", out0_data);
      end else begin
        e = exp0_q.pop_front();
        check("out0_data", out0_data, e);
      end
    end
    if (out1_valid && out1_ready) begin
      if (exp1_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL out1 unexpected beat: got %0h, expected none", out1_data);
      end else begin
        e = exp1_q.pop_front();
        check("out1_data", out1_data, e);
      end
    end
    if (!mode) m_bcnt = 0;
    if (in_valid && in_ready) begin
      d = mode ? m_rr : sel;
      if (d) exp1_q.push_back(in_data);
      else   exp0_q.push_back(in_data);
      if (mode) begin
        m_bcnt++;
        if (m_bcnt == BURST) begin
          m_bcnt = 0;
          m_rr   = ~m_rr;
        end
      end
    end
  endtask

  task automatic step(output logic ir_seen);
    @(negedge clk);
    ir_seen = in_ready;
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_miss++;
    report();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e8;

    // static sel=1
    tbl.push_back('{4'b0101, 8'hA1, 2'b11, 3'b101, 8'd0, 8'd1, 2'b00});
    tbl.push_back('{4'b0101, 8'hA2, 2'b11, 3'b101, 8'd0, 8'd2, 2'b00});
    tbl.push_back('{4'b0101, 8'hA3, 2'b11, 3'b101, 8'd0, 8'd3, 2'b00});
    tbl.push_back('{4'b0100, 8'h00, 2'b11, 3'b100, 8'd0, 8'd3, 2'b00});
    // round-robin, both consumers ready
`ifdef DMUX_BURST_EN
    tbl.push_back('{4'b1001, 8'h10, 2'b11, 3'b110, 8'd1, 8'd3, 2'b00});
    tbl.push_back('{4'b1001, 8'h11, 2'b11, 3'b110, 8'd2, 8'd3, 2'b00});
    tbl.push_back('{4'b1001, 8'h12, 2'b11, 3'b110, 8'd3, 8'd3, 2'b00});
    tbl.push_back('{4'b1001, 8'h13, 2'b11, 3'b110, 8'd4, 8'd3, 2'b10});
    tbl.push_back('{4'b1000, 8'h00, 2'b11, 3'b100, 8'd4, 8'd3, 2'b10});
`else
    tbl.push_back('{4'b1001, 8'h10, 2'b11, 3'b110, 8'd1, 8'd3, 2'b10});
    tbl.push_back('{4'b1001, 8'h11, 2'b11, 3'b101, 8'd1, 8'd4, 2'b00});
    tbl.push_back('{4'b1001, 8'h12, 2'b11, 3'b110, 8'd2, 8'd4, 2'b10});
    tbl.push_back('{4'b1001, 8'h13, 2'b11, 3'b101, 8'd2, 8'd5, 2'b00});
    tbl.push_back('{4'b1000, 8'h00, 2'b11, 3'b100, 8'd2, 8'd5, 2'b00});
`endif
    // backpressure on out0, then pass-through release; then switch sel to 1
    tbl.push_back('{4'b0001, 8'hB1, 2'b01, 3'b110, K0 + 8'd1, K1, {RR1, 1'b0}});
    tbl.push_back('{4'b0001, 8'hB2, 2'b01, 3'b010, K0 + 8'd1, K1, {RR1, 1'b0}});
    tbl.push_back('{4'b0001, 8'hB2, 2'b11, 3'b110, K0 + 8'd2, K1, {RR1, 1'b0}});
    tbl.push_back('{4'b0000, 8'h00, 2'b11, 3'b100, K0 + 8'd2, K1, {RR1, 1'b0}});
    tbl.push_back('{4'b0101, 8'hB3, 2'b11, 3'b101, K0 + 8'd2, K1 + 8'd1, {RR1, 1'b0}});
    tbl.push_back('{4'b0100, 8'h00, 2'b11, 3'b100, K0 + 8'd2, K1 + 8'd1, {RR1, 1'b0}});

    // reset state
    rst = 1'b1;
    drive(4'b0000, 8'h00, 2'b00);
    #2;
    check("rst.out0_valid", out0_valid, 0);
    check("rst.out1_valid", out1_valid, 0);
    check("rst.cnt0", cnt0, 0);
    check("rst.cnt1", cnt1, 0);
    check("rst.rr_ptr", rr_ptr, 0);
    check("rst.flush_done", flush_done, 0);
    check("rst.state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ctl, tbl[i].data, tbl[i].rdy);
      step(ir);
      check($sformatf("v%0d.in_ready", i), ir, tbl[i].e_hs[2]);
      check($sformatf("v%0d.out0_valid", i), out0_valid, tbl[i].e_hs[1]);
      check($sformatf("v%0d.out1_valid", i), out1_valid, tbl[i].e_hs[0]);
      check($sformatf("v%0d.cnt0", i), cnt0, tbl[i].e_cnt0);
      check($sformatf("v%0d.cnt1", i), cnt1, tbl[i].e_cnt1);
      check($sformatf("v%0d.rr_ptr", i), rr_ptr, tbl[i].e_rf[1]);
      check($sformatf("v%0d.flush_done", i), flush_done, tbl[i].e_rf[0]);
    end

    // flush with both holding registers full and consumers stalled
    drive(4'b0001, 8'hC1, 2'b00); step(ir);
    drive(4'b0101, 8'hC2, 2'b00); step(ir);
    drive(4'b0110, 8'h00, 2'b00); step(ir);
    check("flush.enter_state", dbg_state, 1);
    check("flush.full0", out0_valid, 1);
    check("flush.full1", out1_valid, 1);
    drive(4'b0101, 8'hC3, 2'b11); step(ir);
    check("flush.drain_in_ready", ir, 0);
    check("flush.drain_out0_valid", out0_valid, 0);
    check("flush.drain_out1_valid", out1_valid, 0);
    check("flush.drain_done", flush_done, 0);
    check("flush.drain_state", dbg_state, 1);
    step(ir);
    check("flush.empty_in_ready", ir, 0);
    check("flush.done_pulse", flush_done, 1);
    check("flush.done_state", dbg_state, 2);
    step(ir);
    check("flush.done_in_ready", ir, 0);
    check("flush.after_done", flush_done, 0);
    check("flush.run_state", dbg_state, 0);
    step(ir);
    check("flush.resume_in_ready", ir, 1);
    check("flush.resume_out1_valid", out1_valid, 1);
    drive(4'b0100, 8'h00, 2'b11); step(ir);
    check("flush.no_second_pulse", flush_done, 0);
    check("flush.cnt0", cnt0, K0 + 8'd3);
    check("flush.cnt1", cnt1, K1 + 8'd3);

    // 256 back-to-back beats to out0: cnt0 wraps through 0, cnt1 untouched
    drive(4'b0001, 8'h00, 2'b11);
    for (int k = 1; k <= 256; k++) begin
      in_data = 8'($urandom_range(0, 255));
      step(ir);
      e8 = K0 + 8'd3 + 8'(k);
      check($sformatf("wrap.in_ready%0d", k), ir, 1);
      check($sformatf("wrap.cnt0_%0d", k), cnt0, e8);
    end
    drive(4'b0000, 8'h00, 2'b11);
    step(ir);
    step(ir);
    check("wrap.cnt0_final", cnt0, K0 + 8'd3);
    check("wrap.cnt1_final", cnt1, K1 + 8'd3);

    // asynchronous reset while out0 holds a stalled beat
    drive(4'b0001, 8'h5A, 2'b00); step(ir);
    drive(4'b0000, 8'h00, 2'b00);
    check("mid.held", out0_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid.out0_valid", out0_valid, 0);
    check("mid.out0_data", out0_data, 0);
    check("mid.out1_valid", out1_valid, 0);
    check("mid.cnt0", cnt0, 0);
    check("mid.cnt1", cnt1, 0);
    check("mid.rr_ptr", rr_ptr, 0);
    check("mid.state", dbg_state, 0);
    exp0_q.delete();
    exp1_q.delete();
    m_rr   = 1'b0;
    m_bcnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b0001, 8'h77, 2'b11); step(ir);
    check("post_rst.in_ready", ir, 1);
    check("post_rst.cnt0", cnt0, 1);
    drive(4'b0000, 8'h00, 2'b11); step(ir);
    step(ir);

    check("sb.exp0_left", exp0_q.size(), 0);
    check("sb.exp1_left", exp1_q.size(), 0);
    report();
    $finish;
  end

endmodule
